pwm_multi_channel: RTL

//  Multi-channel PWM generator: NUM_CH outputs share one period counter.
//  Per-channel duty and the shared period are written into shadow registers.

---
 rtl/pwm_multi_channel.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator with a shared period counter and shadow/active duty and period registers.
// Optional PWM_CENTER_ALIGN_EN selects an up/down (centre-aligned) counter instead of the edge-aligned up-counter.
module pwm_multi_channel #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned DEFAULT_MAX = 255,
  localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              duty_wr,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_duty,
  input  logic              max_wr,
  input  logic [WIDTH-1:0]  wr_max,
  input  logic              commit,
  output logic              commit_pending,
  output logic              period_start,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam logic [WIDTH-1:0] MAX_RST = WIDTH'(DEFAULT_MAX);

  logic [WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  max_sh_q, max_sh_d;
  logic [WIDTH-1:0]  max_act_q, max_act_d;
  logic [WIDTH-1:0]  duty_sh_q  [NUM_CH];
  logic [WIDTH-1:0]  duty_sh_d  [NUM_CH];
  logic [WIDTH-1:0]  duty_act_q [NUM_CH];
  logic [WIDTH-1:0]  duty_act_d [NUM_CH];
  logic              pend_q, pend_d;
  logic              pstart_q, pstart_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic              wrap_c;
  logic              xfer_c;

`ifdef PWM_CENTER_ALIGN_EN
  typedef enum logic {DIR_UP = 1'b0, DIR_DN = 1'b1} dir_e;
  dir_e dir_q, dir_d;

  // Period ends on the 1->0 step while counting down; max_act<=1 has no down leg.
  assign wrap_c = enable &&
                  (((dir_q == DIR_UP) && (cnt_q == max_act_q) && (max_act_q <= WIDTH'(1))) ||
                   ((dir_q == DIR_DN) && (cnt_q == WIDTH'(1))));

  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!enable || wrap_c) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q == max_act_q) begin
        cnt_d = cnt_q - WIDTH'(1);
        dir_d = DIR_DN;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= DIR_UP;
    end else begin
      dir_q <= dir_d;
    end
  end
`else
  assign wrap_c = enable && (cnt_q == max_act_q);

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || wrap_c) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end
`endif

  // Shadow/active loads are applied at period boundaries or whenever the counter is idle.
  assign xfer_c = (pend_q || commit) && (!enable || wrap_c);

  always_comb begin
    duty_sh_d  = duty_sh_q;
    duty_act_d = duty_act_q;
    max_sh_d   = max_sh_q;
    max_act_d  = max_act_q;
    pend_d     = pend_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (duty_wr && (wr_ch == CH_W'(i))) begin
        duty_sh_d[i] = wr_duty;
      end
    end
    if (max_wr) begin
      max_sh_d = wr_max;
    end
    // Same-cycle shadow writes are forwarded into the active set.
    if (xfer_c) begin
      duty_act_d = duty_sh_d;
      max_act_d  = max_sh_d;
      pend_d     = 1'b0;
    end else if (commit) begin
      pend_d = 1'b1;
    end
  end

  always_comb begin
    pwm_d    = '0;
    pstart_d = wrap_c;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = enable && (cnt_q < duty_act_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      max_sh_q  <= MAX_RST;
      max_act_q <= MAX_RST;
      pend_q    <= 1'b0;
      pstart_q  <= 1'b0;
      pwm_q     <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        duty_sh_q[i]  <= '0;
        duty_act_q[i] <= '0;
      end
    end else begin
      cnt_q      <= cnt_d;
      max_sh_q   <= max_sh_d;
      max_act_q  <= max_act_d;
      pend_q     <= pend_d;
      pstart_q   <= pstart_d;
      pwm_q      <= pwm_d;
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
    end
  end

  assign commit_pending = pend_q;
  assign period_start   = pstart_q;
  assign pwm_out        = pwm_q;

endmodule
